demux_input: RTL and testbench

Input-side stream splitter for the video pipeline; the counterpart of the output mux that recombines the bypass and scaler paths. It registers the incoming sync/den/data stream and detects frame starts on the vsync rising edge. At each frame start it captures the mirror/blur mode controls, so the mode never changes mid-frame. Each frame's stream goes either to the scaler path or to the bypass path, and the block also provides pixel and line position counters.

---
 rtl/demux_input.sv | 199 +++++++++++++++++++
 tb/tb_demux_input.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_input.sv
`default_nettype none
// ============================================================================
// demux_input : registers the input video stream, locks on the first vsync
// rise and routes each frame to the scaler or bypass path with pixel/line counts.
// Revision 1.0
// ============================================================================
module demux_input #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  i_mirror_mode,
    input  logic                  i_blur_mode,
    input  logic                  i_vsync,
    input  logic                  i_hsync,
    input  logic                  i_den,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_mirror_mode_cap,
    output logic                  o_blur_mode_cap,
    output logic                  o_vsync_bypass,
    output logic                  o_hsync_bypass,
    output logic                  o_den_bypass,
    output logic [DATA_WIDTH-1:0] o_data_bypass,
    output logic                  o_vsync_scaler,
    output logic                  o_hsync_scaler,
    output logic                  o_den_scaler,
    output logic [DATA_WIDTH-1:0] o_data_scaler,
    output logic                  o_frame_start,
    output logic [CNT_WIDTH-1:0]  o_pix_cnt,
    output logic [CNT_WIDTH-1:0]  o_line_cnt
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Stage 1: input registers plus one-cycle history for edge detection
    logic                  vsync_q, vsync_dly_q;
    logic                  hsync_q, hsync_dly_q;
    logic                  den_q, den_dly_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  mirror_q, blur_q;

    // Stage 2: output registers
    logic [0:0]            state_q, state_d;
    logic                  mirror_cap_q, mirror_cap_d;
    logic                  blur_cap_q, blur_cap_d;
    logic                  vsync_byp_q, vsync_byp_d;
    logic                  hsync_byp_q, hsync_byp_d;
    logic                  den_byp_q, den_byp_d;
    logic [DATA_WIDTH-1:0] data_byp_q, data_byp_d;
    logic                  vsync_scl_q, vsync_scl_d;
    logic                  hsync_scl_q, hsync_scl_d;
    logic                  den_scl_q, den_scl_d;
    logic [DATA_WIDTH-1:0] data_scl_q, data_scl_d;
    logic                  frame_start_q, frame_start_d;
    logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0]  line_cnt_q, line_cnt_d;

    logic w_fs, w_hs_rise, w_den_fall, w_active, w_scaler_sel, w_den_out;

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            vsync_q     <= 1'b0;
            vsync_dly_q <= 1'b0;
            hsync_q     <= 1'b0;
            hsync_dly_q <= 1'b0;
            den_q       <= 1'b0;
            den_dly_q   <= 1'b0;
            data_q      <= '0;
            mirror_q    <= 1'b0;
            blur_q      <= 1'b0;
        end else begin
            vsync_q     <= i_vsync;
            vsync_dly_q <= vsync_q;
            hsync_q     <= i_hsync;
            hsync_dly_q <= hsync_q;
            den_q       <= i_den;
            den_dly_q   <= den_q;
            data_q      <= i_data;
            mirror_q    <= i_mirror_mode;
            blur_q      <= i_blur_mode;
        end
    end

    assign w_fs       = vsync_q & ~vsync_dly_q;
    assign w_hs_rise  = hsync_q & ~hsync_dly_q;
    assign w_den_fall = den_dly_q & ~den_q;
    // The first frame start is processed as if already locked
    assign w_active   = (state_q == ST_LOCKED) | w_fs;
    assign w_den_out  = den_byp_q | den_scl_q;

    always_comb begin
        state_d       = state_q;
        mirror_cap_d  = mirror_cap_q;
        blur_cap_d    = blur_cap_q;
        vsync_byp_d   = 1'b0;
        hsync_byp_d   = 1'b0;
        den_byp_d     = 1'b0;
        data_byp_d    = '0;
        vsync_scl_d   = 1'b0;
        hsync_scl_d   = 1'b0;
        den_scl_d     = 1'b0;
        data_scl_d    = '0;
        frame_start_d = 1'b0;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        w_scaler_sel  = 1'b0;

        if (w_active) begin
            state_d       = ST_LOCKED;
            frame_start_d = w_fs;
            if (w_fs) begin
                mirror_cap_d = mirror_q;
                blur_cap_d   = blur_q;
            end

            // Live modes take effect on the frame-start cycle itself
            w_scaler_sel = w_fs ? (mirror_q | blur_q) : (mirror_cap_q | blur_cap_q);
            if (w_scaler_sel) begin
                vsync_scl_d = vsync_q;
                hsync_scl_d = hsync_q;
                den_scl_d   = den_q;
                data_scl_d  = data_q;
            end else begin
                vsync_byp_d = vsync_q;
                hsync_byp_d = hsync_q;
                den_byp_d   = den_q;
                data_byp_d  = data_q;
            end

            if (w_fs || w_hs_rise) begin
                pix_cnt_d = CNT_ZERO;
            end else if (w_den_out && (pix_cnt_q != CNT_MAX)) begin
                pix_cnt_d = pix_cnt_q + CNT_ONE;
            end

            if (w_fs) begin
                line_cnt_d = CNT_ZERO;
            end else if (w_den_fall && (line_cnt_q != CNT_MAX)) begin
                line_cnt_d = line_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q       <= ST_SEARCH;
            mirror_cap_q  <= 1'b0;
            blur_cap_q    <= 1'b0;
            vsync_byp_q   <= 1'b0;
            hsync_byp_q   <= 1'b0;
            den_byp_q     <= 1'b0;
            data_byp_q    <= '0;
            vsync_scl_q   <= 1'b0;
            hsync_scl_q   <= 1'b0;
            den_scl_q     <= 1'b0;
            data_scl_q    <= '0;
            frame_start_q <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            mirror_cap_q  <= mirror_cap_d;
            blur_cap_q    <= blur_cap_d;
            vsync_byp_q   <= vsync_byp_d;
            hsync_byp_q   <= hsync_byp_d;
            den_byp_q     <= den_byp_d;
            data_byp_q    <= data_byp_d;
            vsync_scl_q   <= vsync_scl_d;
            hsync_scl_q   <= hsync_scl_d;
            den_scl_q     <= den_scl_d;
            data_scl_q    <= data_scl_d;
            frame_start_q <= frame_start_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
        end
    end

    assign o_mirror_mode_cap = mirror_cap_q;
    assign o_blur_mode_cap   = blur_cap_q;
    assign o_vsync_bypass    = vsync_byp_q;
    assign o_hsync_bypass    = hsync_byp_q;
    assign o_den_bypass      = den_byp_q;
    assign o_data_bypass     = data_byp_q;
    assign o_vsync_scaler    = vsync_scl_q;
    assign o_hsync_scaler    = hsync_scl_q;
    assign o_den_scaler      = den_scl_q;
    assign o_data_scaler     = data_scl_q;
    assign o_frame_start     = frame_start_q;
    assign o_pix_cnt         = pix_cnt_q;
    assign o_line_cnt        = line_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_input.sv
`default_nettype none
// ============================================================================
// tb_demux_input : randomized frames checked cycle by cycle against a
// behavioural model of the splitter. Revision 1.0
// ============================================================================
module tb_demux_input;

    localparam int DW   = 8;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_mirror_mode, i_blur_mode, i_vsync, i_hsync, i_den;
    logic [DW-1:0] i_data;
    logic          o_mirror_mode_cap, o_blur_mode_cap;
    logic          o_vsync_bypass, o_hsync_bypass, o_den_bypass;
    logic [DW-1:0] o_data_bypass;
    logic          o_vsync_scaler, o_hsync_scaler, o_den_scaler;
    logic [DW-1:0] o_data_scaler;
    logic          o_frame_start;
    logic [CW-1:0] o_pix_cnt, o_line_cnt;

    always #5 clk = ~clk;

    demux_input #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .I_CLK(clk), .I_RST(rst),
        .i_mirror_mode(i_mirror_mode), .i_blur_mode(i_blur_mode),
        .i_vsync(i_vsync), .i_hsync(i_hsync), .i_den(i_den), .i_data(i_data),
        .o_mirror_mode_cap(o_mirror_mode_cap), .o_blur_mode_cap(o_blur_mode_cap),
        .o_vsync_bypass(o_vsync_bypass), .o_hsync_bypass(o_hsync_bypass),
        .o_den_bypass(o_den_bypass), .o_data_bypass(o_data_bypass),
        .o_vsync_scaler(o_vsync_scaler), .o_hsync_scaler(o_hsync_scaler),
        .o_den_scaler(o_den_scaler), .o_data_scaler(o_data_scaler),
        .o_frame_start(o_frame_start), .o_pix_cnt(o_pix_cnt), .o_line_cnt(o_line_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: inputs seen at the last three edges; output reflects the middle one
    typedef struct packed {
        logic          v, h, d;
        logic [DW-1:0] data;
        logic          m, b;
    } in_t;

    in_t q[$];
    bit  m_locked, cap_m, cap_b, den_shown;
    int  e_pix, e_line;
    bit  e_fs, e_vs_b, e_hs_b, e_de_b, e_vs_s, e_hs_s, e_de_s;
    logic [DW-1:0] e_dat_b, e_dat_s;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 3; i++) q.push_back('0);
        m_locked = 0; cap_m = 0; cap_b = 0; den_shown = 0;
        e_pix = 0; e_line = 0; e_fs = 0;
        e_vs_b = 0; e_hs_b = 0; e_de_b = 0; e_dat_b = '0;
        e_vs_s = 0; e_hs_s = 0; e_de_s = 0; e_dat_s = '0;
    endtask

    task automatic model_clock();
        in_t cur, now, pri;
        bit  fs;
        if (rst) begin
            model_reset();
            return;
        end
        cur = '{v: i_vsync, h: i_hsync, d: i_den, data: i_data, m: i_mirror_mode, b: i_blur_mode};
        q.push_back(cur);
        if (q.size() > 3) void'(q.pop_front());
        now = q[1];
        pri = q[0];
        fs  = now.v && !pri.v;
        e_vs_b = 0; e_hs_b = 0; e_de_b = 0; e_dat_b = '0;
        e_vs_s = 0; e_hs_s = 0; e_de_s = 0; e_dat_s = '0;
        e_fs = 0;
        if (m_locked || fs) begin
            m_locked = 1;
            e_fs = fs;
            if (fs) begin
                cap_m = now.m;
                cap_b = now.b;
            end
            if (fs || (now.h && !pri.h)) e_pix = 0;
            else if (den_shown && e_pix < CMAX) e_pix = e_pix + 1;
            if (fs) e_line = 0;
            else if (pri.d && !now.d && e_line < CMAX) e_line = e_line + 1;
            if (cap_m || cap_b) begin
                e_vs_s = now.v; e_hs_s = now.h; e_de_s = now.d; e_dat_s = now.data;
            end else begin
                e_vs_b = now.v; e_hs_b = now.h; e_de_b = now.d; e_dat_b = now.data;
            end
        end
        den_shown = e_de_b || e_de_s;
    endtask

    task automatic compare_all();
        check("mirror_cap", o_mirror_mode_cap, cap_m);
        check("blur_cap",   o_blur_mode_cap,   cap_b);
        check("vsync_byp",  o_vsync_bypass,    e_vs_b);
        check("hsync_byp",  o_hsync_bypass,    e_hs_b);
        check("den_byp",    o_den_bypass,      e_de_b);
        check("data_byp",   o_data_bypass,     e_dat_b);
        check("vsync_scl",  o_vsync_scaler,    e_vs_s);
        check("hsync_scl",  o_hsync_scaler,    e_hs_s);
        check("den_scl",    o_den_scaler,      e_de_s);
        check("data_scl",   o_data_scaler,     e_dat_s);
        check("frame_start", o_frame_start,    e_fs);
        check("pix_cnt",    o_pix_cnt,         e_pix);
        check("line_cnt",   o_line_cnt,        e_line);
    endtask

    task automatic step(input bit v, input bit h, input bit d, input logic [DW-1:0] dat);
        i_vsync = v; i_hsync = h; i_den = d; i_data = dat;
        @(posedge clk);
        @(negedge clk);
        model_clock();
        compare_all();
    endtask

    task automatic frame(input int lines, input int pix, input bit mir, input bit blr,
                         input int toggle_line, input bit rnd_data);
        i_mirror_mode = mir;
        i_blur_mode   = blr;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        for (int l = 0; l < lines; l++) begin
            if (l == toggle_line) i_blur_mode = ~i_blur_mode;
            step(0, 1, 0, '0);
            step(0, 0, 0, '0);
            for (int p = 0; p < pix; p++)
                step(0, 0, 1, rnd_data ? DW'($urandom) : DW'(p));
            step(0, 0, 0, '0);
            step(0, 0, 0, '0);
        end
    endtask

    initial begin
        rst = 1'b1;
        i_mirror_mode = 0; i_blur_mode = 0;
        i_vsync = 0; i_hsync = 0; i_den = 0; i_data = '0;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 1'($urandom), 1'($urandom), DW'($urandom));

        // Release mid-frame: den toggling, no vsync rise, nothing may appear
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(0, 1'($urandom), 1'($urandom), DW'($urandom));

        frame(4, 8, 0, 0, -1, 0);   // bypass, data = pixel index
        frame(4, 8, 0, 1, 2, 1);    // scaler, blur dropped at line 2
        frame(3, 8, 0, 0, -1, 1);   // back to bypass
        frame(10, 10, 1, 0, -1, 1); // pixel and line counters saturate

        // Simultaneous vsync and hsync rise mid-line
        i_mirror_mode = 0; i_blur_mode = 0;
        step(0, 1, 0, '0);
        for (int p = 0; p < 4; p++) step(0, 0, 1, DW'($urandom));
        step(1, 1, 1, DW'($urandom));
        step(1, 0, 1, DW'($urandom));
        check("sim_frame_start", o_frame_start, 1);
        check("sim_pix_cnt", o_pix_cnt, 0);
        check("sim_line_cnt", o_line_cnt, 0);
        step(0, 0, 0, '0);

        // Asynchronous reset while the scaler path is live
        i_blur_mode = 1;
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        for (int p = 0; p < 3; p++) step(0, 0, 1, 8'hA5);
        check("pre_arst_den_scl", o_den_scaler, 1);
        rst = 1'b1;
        #1;
        check("arst_den_scl", o_den_scaler, 0);
        check("arst_data_scl", o_data_scaler, 0);
        check("arst_blur_cap", o_blur_mode_cap, 0);
        check("arst_pix_cnt", o_pix_cnt, 0);
        model_reset();
        step(0, 0, 1, 8'h5A);
        step(0, 0, 1, 8'h5A);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(0, 1'($urandom), 1'($urandom), DW'($urandom));

        // Random frames with random modes and random mid-frame toggles
        for (int f = 0; f < 8; f++)
            frame($urandom_range(1, 5), $urandom_range(1, 12), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 5), 1);
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
